// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: synchroniser, stable-count debounce, press/release strobes.
// Optional auto-repeat of press_o while a button is held: define BTN_AUTOREPEAT_EN.
module btn_debounce_multi #(
   parameter int N_BTN         = 5,
   parameter int STABLE_CYCLES = 500000,
   parameter int SYNC_STAGES   = 2,
   parameter int REPEAT_DELAY  = 50000000,
   parameter int REPEAT_PERIOD = 10000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_i,
   output logic [N_BTN-1:0] btn_o,
   output logic [N_BTN-1:0] press_o,
   output logic [N_BTN-1:0] release_o,
   output logic             any_press_o
);

   localparam int CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   generate
      if ((STABLE_CYCLES < 2) || (SYNC_STAGES < 2) || (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1))
      begin : g_bad_param
         $error("btn_debounce_multi: illegal parameter value");
      end
   endgenerate

   logic [N_BTN-1:0] w_press_nxt;
   logic             r_any_press;

   genvar g;
   generate
      for (g = 0; g < N_BTN; g++) begin : g_ch
         logic [SYNC_STAGES-1:0] r_sync;
         logic [CNT_W-1:0]       r_cnt;
         logic                   r_btn;
         logic                   r_press;
         logic                   r_release;
         logic                   w_sync;
         logic                   w_accept;
         logic                   w_rise;
         logic                   w_fall;

         assign w_sync   = r_sync[SYNC_STAGES-1];
         assign w_accept = (w_sync != r_btn) && (r_cnt == CNT_MAX);
         assign w_rise   = w_accept & w_sync;
         assign w_fall   = w_accept & ~w_sync;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_sync <= '0;
            end else begin
               r_sync <= {r_sync[SYNC_STAGES-2:0], btn_i[g]};
            end
         end

         // Any return to the accepted level restarts the window from zero.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt <= '0;
               r_btn <= 1'b0;
            end else if (w_sync == r_btn) begin
               r_cnt <= '0;
            end else if (w_accept) begin
               r_btn <= w_sync;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end

`ifdef BTN_AUTOREPEAT_EN
         localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int REP_W   = $clog2(REP_MAX + 1);

         logic [REP_W-1:0] r_rep_cnt;
         logic             r_rep_first;
         logic [REP_W-1:0] w_rep_target;
         logic             w_rep_fire;

         assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
         // A repeat due on the release edge is dropped so press and release never coincide.
         assign w_rep_fire   = r_btn && !w_fall && (r_rep_cnt == w_rep_target);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_rep_cnt   <= '0;
               r_rep_first <= 1'b1;
            end else if (!r_btn || w_fall) begin
               r_rep_cnt   <= '0;
               r_rep_first <= 1'b1;
            end else if (w_rep_fire) begin
               r_rep_cnt   <= '0;
               r_rep_first <= 1'b0;
            end else begin
               r_rep_cnt <= r_rep_cnt + 1'b1;
            end
         end

         assign w_press_nxt[g] = w_rise | w_rep_fire;
`else
         assign w_press_nxt[g] = w_rise;
`endif

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_press   <= 1'b0;
               r_release <= 1'b0;
            end else begin
               r_press   <= w_press_nxt[g];
               r_release <= w_fall;
            end
         end

         assign btn_o[g]     = r_btn;
         assign press_o[g]   = r_press;
         assign release_o[g] = r_release;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_any_press <= 1'b0;
      end else begin
         r_any_press <= |w_press_nxt;
      end
   end

   assign any_press_o = r_any_press;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed self-checking bench for btn_debounce_multi (N_BTN=5, STABLE_CYCLES=4, SYNC_STAGES=2).
module tb_btn_debounce_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] btn_i = 5'b00000;
   logic [4:0] btn_o;
   logic [4:0] press_o;
   logic [4:0] release_o;
   logic       any_press_o;

   int n_pass  = 0;
   int n_total = 0;

   btn_debounce_multi #(
      .N_BTN(5),
      .STABLE_CYCLES(4),
      .SYNC_STAGES(2),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_i(btn_i),
      .btn_o(btn_o),
      .press_o(press_o),
      .release_o(release_o),
      .any_press_o(any_press_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      btn_i = 5'b00000;
      repeat (3) tick();
      n_total++;
      if (btn_o !== 5'b00000) $display("FAIL reset_btn: got %b expected 00000", btn_o);
      else n_pass++;
      n_total++;
      if (press_o !== 5'b00000 || release_o !== 5'b00000 || any_press_o !== 1'b0)
         $display("FAIL reset_strobes: press %b release %b any %b expected all 0", press_o, release_o, any_press_o);
      else n_pass++;
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_single_press();
      logic [4:0] exp_btn, exp_press, exp_rel;
      btn_i = 5'b00001;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_btn   = (k >= 6) ? 5'b00001 : 5'b00000;
         exp_press = (k == 6) ? 5'b00001 : 5'b00000;
         n_total++;
         if (btn_o !== exp_btn) $display("FAIL single_btn k=%0d: got %b expected %b", k, btn_o, exp_btn);
         else n_pass++;
         n_total++;
         if (press_o !== exp_press || any_press_o !== (|exp_press))
            $display("FAIL single_press k=%0d: got %b/%b expected %b/%b", k, press_o, any_press_o, exp_press, |exp_press);
         else n_pass++;
         n_total++;
         if (release_o !== 5'b00000) $display("FAIL single_rel k=%0d: got %b expected 00000", k, release_o);
         else n_pass++;
      end
      btn_i = 5'b00000;
      for (int k = 1; k <= 7; k++) begin
         tick();
         exp_btn = (k >= 6) ? 5'b00000 : 5'b00001;
         exp_rel = (k == 6) ? 5'b00001 : 5'b00000;
         n_total++;
         if (btn_o !== exp_btn || release_o !== exp_rel || press_o !== 5'b00000)
            $display("FAIL single_release k=%0d: btn %b rel %b press %b expected %b %b 00000",
                     k, btn_o, release_o, press_o, exp_btn, exp_rel);
         else n_pass++;
      end
   endtask

   task automatic test_bounce();
      int presses;
      logic [4:0] exp_btn;
      for (int k = 0; k < 8; k++) begin
         btn_i[1] = (k % 2 == 0);
         tick();
         n_total++;
         if (btn_o[1] !== 1'b0 || press_o[1] !== 1'b0)
            $display("FAIL bounce_hold k=%0d: btn %b press %b expected 0 0", k, btn_o[1], press_o[1]);
         else n_pass++;
      end
      btn_i[1] = 1'b1;
      presses = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (press_o[1] === 1'b1) presses++;
         exp_btn = (k >= 6) ? 5'b00010 : 5'b00000;
         if (k == 5 || k == 6) begin
            n_total++;
            if (btn_o !== exp_btn) $display("FAIL bounce_rise k=%0d: got %b expected %b", k, btn_o, exp_btn);
            else n_pass++;
         end
      end
      n_total++;
      if (presses != 1) $display("FAIL bounce_press_count: got %0d expected 1", presses);
      else n_pass++;
      btn_i = 5'b00000;
      repeat (8) tick();
   endtask

   task automatic test_glitch();
      int releases;
      btn_i[2] = 1'b1;
      repeat (8) tick();
      n_total++;
      if (btn_o !== 5'b00100) $display("FAIL glitch_setup: got %b expected 00100", btn_o);
      else n_pass++;
      releases = 0;
      btn_i[2] = 1'b0;
      repeat (3) begin
         tick();
         if (release_o[2] === 1'b1) releases++;
      end
      btn_i[2] = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (release_o[2] === 1'b1) releases++;
         if (btn_o[2] !== 1'b1) releases += 100;
      end
      n_total++;
      if (releases != 0) $display("FAIL glitch_3cyc: got release score %0d expected 0", releases);
      else n_pass++;
      releases = 0;
      btn_i[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 5) btn_i[2] = 1'b1;
         tick();
         if (release_o[2] === 1'b1) releases++;
         if (k == 6) begin
            n_total++;
            if (btn_o[2] !== 1'b0 || release_o[2] !== 1'b1)
               $display("FAIL glitch_4cyc k=6: btn %b rel %b expected 0 1", btn_o[2], release_o[2]);
            else n_pass++;
         end
      end
      n_total++;
      if (releases != 1) $display("FAIL glitch_4cyc_count: got %0d expected 1", releases);
      else n_pass++;
      btn_i = 5'b00000;
      repeat (12) tick();
   endtask

   task automatic test_simultaneous();
      btn_i = 5'b10110;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k >= 5) begin
            n_total++;
            if (btn_o !== ((k >= 6) ? 5'b10110 : 5'b00000) ||
                press_o !== ((k == 6) ? 5'b10110 : 5'b00000) ||
                any_press_o !== (k == 6))
               $display("FAIL simul_press k=%0d: btn %b press %b any %b", k, btn_o, press_o, any_press_o);
            else n_pass++;
         end
      end
      btn_i = 5'b00000;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k >= 5) begin
            n_total++;
            if (btn_o !== ((k >= 6) ? 5'b00000 : 5'b10110) ||
                release_o !== ((k == 6) ? 5'b10110 : 5'b00000) ||
                press_o !== 5'b00000 || any_press_o !== 1'b0)
               $display("FAIL simul_release k=%0d: btn %b rel %b press %b any %b", k, btn_o, release_o, press_o, any_press_o);
            else n_pass++;
         end
      end
   endtask

   task automatic test_reset_midcount();
      int presses;
      btn_i = 5'b01000;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (btn_o !== 5'b00000 || press_o !== 5'b00000 || release_o !== 5'b00000 || any_press_o !== 1'b0)
         $display("FAIL rstmid_assert: btn %b press %b rel %b any %b expected 0", btn_o, press_o, release_o, any_press_o);
      else n_pass++;
      repeat (2) tick();
      rst = 1'b0;
      presses = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (press_o[3] === 1'b1) presses++;
         if (k == 5 || k == 6) begin
            n_total++;
            if (btn_o !== ((k == 6) ? 5'b01000 : 5'b00000) || press_o !== ((k == 6) ? 5'b01000 : 5'b00000))
               $display("FAIL rstmid_rise k=%0d: btn %b press %b", k, btn_o, press_o);
            else n_pass++;
         end
      end
      n_total++;
      if (presses != 1) $display("FAIL rstmid_press_count: got %0d expected 1", presses);
      else n_pass++;
      btn_i = 5'b00000;
      repeat (8) tick();
   endtask

`ifdef BTN_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int  hits, extra;
      bit  exp_p;
      hits  = 0;
      extra = 0;
      btn_i = 5'b00001;
      for (int k = 1; k <= 80; k++) begin
         if (k == 61) btn_i = 5'b00000;
         tick();
         exp_p = (k == 6) || (k == 26) || (k == 34) || (k == 42) || (k == 50) || (k == 58);
         if (press_o[0] === 1'b1 && exp_p) hits++;
         if (press_o[0] !== exp_p) extra++;
      end
      n_total++;
      if (hits != 6 || extra != 0) $display("FAIL autorepeat: got %0d expected hits, %0d wrong cycles; need 6 and 0", hits, extra);
      else n_pass++;
   endtask
`else
   task automatic test_no_repeat();
      int presses;
      presses = 0;
      btn_i = 5'b00001;
      repeat (40) begin
         tick();
         if (press_o[0] === 1'b1) presses++;
      end
      n_total++;
      if (presses != 1) $display("FAIL no_repeat: got %0d presses expected 1", presses);
      else n_pass++;
      btn_i = 5'b00000;
      repeat (8) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_press();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_reset_midcount();
`ifdef BTN_AUTOREPEAT_EN
      test_autorepeat();
`else
      test_no_repeat();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel push-button conditioner; successor to the fixed 5-button btn_debouce.
- Per channel: synchroniser, stable-count debounce, registered debounced level, and single-cycle press/release strobes.
- Sits between the board button pins and the UART/control logic, so downstream blocks consume clean levels and strobes instead of doing their own edge detection.
- Adds async reset, a programmable stable window and an optional auto-repeat.

Parameters:
- N_BTN, 5, number of independent button channels.
- STABLE_CYCLES, 500000, consecutive clk cycles a new level must persist before acceptance; legal range ≥2.
- SYNC_STAGES, 2, synchroniser flop depth; legal range ≥2.
- REPEAT_DELAY, 50000000, cycles held before the first auto-repeat strobe (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat strobes (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn_i  input  N_BTN  raw asynchronous button levels, active-high.
- btn_o  output  N_BTN  debounced level.
- press_o  output  N_BTN  one-cycle strobe per channel on accepted 0→1 (plus repeats when enabled).
- release_o  output  N_BTN  one-cycle strobe per channel on accepted 1→0.
- any_press_o  output  1  registered OR of press_o conditions; asserted in the same cycle as press_o.

Behaviour:
- Reset (async assert, sync release):
  - all sync flops, counters, btn_o, press_o, release_o and any_press_o go to 0.
  - Leaving reset with a button held: treated as a 0→1 transition and debounced normally.
- Synchroniser: SYNC_STAGES flops per channel; last stage = sync[i]. No logic between stages.
- Counter: per channel, width $clog2(STABLE_CYCLES), clk_cnt[i]. Each edge:
  - if sync[i]==btn_o[i]: clk_cnt[i]<=0.
  - else if clk_cnt[i]==STABLE_CYCLES-1: btn_o[i]<=sync[i], clk_cnt[i]<=0.
  - else: clk_cnt[i]<=clk_cnt[i]+1.
- Latency: a level held from the edge that first samples it (edge 1) appears on btn_o at edge SYNC_STAGES+STABLE_CYCLES.
- Glitch rejection: any sync mismatch run shorter than STABLE_CYCLES is rejected; counter restarts from 0 on every return to the current btn_o value. No partial credit, no wrap: the counter never exceeds STABLE_CYCLES-1.
- Strobes:
  - press_o[i] is registered and asserted exactly in the cycle where btn_o[i] first reads 1; release_o[i] likewise when btn_o[i] first reads 0.
  - Both strobes deassert the next cycle.
  - press_o and release_o are never simultaneously high on one channel.
- Channel independence: channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes, and any_press_o is a single cycle.
- Reset mid-count: counters clear, btn_o=0, no strobe generated by reset itself.
- State per channel is two-state only: IDLE_LOW/IDLE_HIGH (btn_o) plus counting. No encoded FSM register beyond btn_o and clk_cnt.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - per-channel repeat counter starts at 0 when press_o fires and runs while btn_o[i]=1.
  - at REPEAT_DELAY cycles after the press strobe, press_o[i] pulses again; thereafter it pulses every REPEAT_PERIOD cycles.
  - counter clears on btn_o[i]=0 or rst.
  - release_o is unaffected.
- Undefined: no repeat logic or counters are synthesised, and press_o fires once per accepted press. REPEAT_* parameters are accepted but ignored.

Test Plan:
- Bench parameters for all scenarios: N_BTN=5, STABLE_CYCLES=4, SYNC_STAGES=2, 10 ns clk.
- Reset then btn_i=5'b00001 held → btn_o=5'b00001 at the 6th edge after first sample; press_o[0] high exactly 1 cycle; release_o=0.
- Bounce: btn_i[1] toggles 1,0,1,0 each cycle for 8 cycles, then held 1 → btn_o[1] stays 0 through bouncing and rises 6 edges after the final hold begins; exactly one press_o[1] pulse.
- Glitch: btn_o[2]=1 stable, btn_i[2]=0 for 3 cycles then back to 1 → btn_o[2] remains 1, no release_o.
- Simultaneous: btn_i 5'b00000→5'b10110 on one edge → btn_o=5'b10110 and press_o=5'b10110 in the same cycle, any_press_o high for 1 cycle. Later btn_i→0 gives release_o=5'b10110 together.
- Reset mid-count: btn_i[3]=1, assert rst after 3 cycles, release 2 cycles later with btn_i[3] still 1 → all outputs 0 during rst; btn_o[3] rises 6 edges after rst release with one press_o[3] pulse.
- BTN_AUTOREPEAT_EN with REPEAT_DELAY=20, REPEAT_PERIOD=8: hold btn_i[0]=1 for 60 cycles → press_o[0] pulses at acceptance, +20, +28, +36 … while held; no pulses after release.
